// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the two-port SRAM arbiter.
//   state_t          : arbiter FSM state encoding (IDLE, ACCESS, DONE)
//   PORT_IF/PORT_MEM : requester indices (instruction fetch, MEM-stage data)
//   DEF_*            : default timing and address-map constants
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic PORT_IF  = 1'b0;
  localparam logic PORT_MEM = 1'b1;

  localparam int DEF_WAIT_CYCLES = 5;
  localparam int DEF_BASE_ADDR   = 1024;
  localparam int DEF_ADDR_W      = 17;

endpackage

// File: rtl/sram_rr_grant.sv
// Combinational two-way round-robin picker.
//   req[1:0]    : per-port request (rd|wr)
//   last_grant  : port granted most recently
//   grant_valid : at least one port is requesting
//   grant_idx   : port to serve; on a tie, the port that was not served last
module sram_rr_grant (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  always_comb begin
    grant_valid = |req;
    grant_idx   = (req == 2'b11) ? ~last_grant : req[1];
  end

endmodule

// File: rtl/sram_arbiter.sv
// Arbiter sharing one asynchronous SRAM between instruction fetch (port 0)
// and MEM-stage data access (port 1).
//   clk, rst              : clock, asynchronous active-low reset
//   pN_rd/pN_wr           : request, held until pN_ready (rd&wr = write)
//   pN_addr/pN_wdata      : byte address and write data
//   pN_rdata/pN_ready     : read data (held) and one-cycle completion pulse
//   sram_addr/dq/we_n     : SRAM pins; dq driven only while we_n is low
//   dbg_state             : current FSM state
//
// Handshake: a port requests by holding rd|wr high; the arbiter samples
// requests only in IDLE, and answers with exactly one cycle of pN_ready.
// The requester must drop or change its request in the cycle it sees ready,
// otherwise the following IDLE cycle starts another access.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int BASE_ADDR   = DEF_BASE_ADDR,
  parameter int ADDR_W      = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_rd,
  input  logic              p0_wr,
  input  logic [31:0]       p0_addr,
  input  logic [31:0]       p0_wdata,
  output logic [31:0]       p0_rdata,
  output logic              p0_ready,
  input  logic              p1_rd,
  input  logic              p1_wr,
  input  logic [31:0]       p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic [31:0]       p1_rdata,
  output logic              p1_ready,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [31:0]       sram_dq,
  output logic              sram_we_n,
  output state_t            dbg_state
);

  localparam int CNT_W = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [31:0] BASE_32 = 32'(BASE_ADDR);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              last_grant_q;
  logic              port_q;
  logic              wr_q;
  logic [31:0]       wdata_q;

  logic              grant_valid;
  logic              grant_idx;
  logic              sel_wr;
  logic [31:0]       sel_addr;
  logic [31:0]       sel_wdata;
  logic [ADDR_W-1:0] sel_word;
  logic              access_last;

  sram_rr_grant u_grant (
    .req         ({p1_rd | p1_wr, p0_rd | p0_wr}),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Operand mux for the port about to be granted; a write wins over a read.
  always_comb begin
    sel_wr    = (grant_idx == PORT_MEM) ? p1_wr    : p0_wr;
    sel_addr  = (grant_idx == PORT_MEM) ? p1_addr  : p0_addr;
    sel_wdata = (grant_idx == PORT_MEM) ? p1_wdata : p0_wdata;
    // Truncation makes addresses outside the window wrap modulo 2^ADDR_W.
    sel_word  = ADDR_W'((sel_addr - BASE_32) >> 2);
  end

  assign access_last = (cnt_q == CNT_LAST);
  assign dbg_state   = state_q;

  // Bus drive keyed off the registered strobe, so reset releases it at once.
  assign sram_dq = sram_we_n ? {32{1'bz}} : wdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = ACCESS;
      ACCESS:  if (access_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      last_grant_q <= PORT_MEM;
      port_q       <= PORT_IF;
      wr_q         <= 1'b0;
      wdata_q      <= '0;
      sram_addr    <= '0;
      sram_we_n    <= 1'b1;
      p0_ready     <= 1'b0;
      p1_ready     <= 1'b0;
      p0_rdata     <= '0;
      p1_rdata     <= '0;
    end else begin
      p0_ready <= 1'b0;
      p1_ready <= 1'b0;
      case (state_q)
        IDLE: begin
          sram_we_n <= 1'b1;
          if (grant_valid) begin
            port_q       <= grant_idx;
            last_grant_q <= grant_idx;
            wr_q         <= sel_wr;
            wdata_q      <= sel_wdata;
            sram_addr    <= sel_word;
            cnt_q        <= '0;
            // Write strobe is low only for the cnt=0 cycle.
            sram_we_n    <= ~sel_wr;
          end
        end
        ACCESS: begin
          // Strobe back high after one cycle leaves turnaround time.
          sram_we_n <= 1'b1;
          cnt_q     <= cnt_q + CNT_W'(1);
          if (access_last) begin
            if (!wr_q) begin
              if (port_q == PORT_MEM) p1_rdata <= sram_dq;
              else                    p0_rdata <= sram_dq;
            end
            if (port_q == PORT_MEM) p1_ready <= 1'b1;
            else                    p0_ready <= 1'b1;
          end
        end
        default: sram_we_n <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam int AW = 17;
  localparam int RW = 1 + 1 + AW + 32;  // {port, is_read, word, rdata}
  localparam int WW = AW + 32;          // {word, wdata}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic          p0_rd = 0, p0_wr = 0, p1_rd = 0, p1_wr = 0;
  logic [31:0]   p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
  logic [31:0]   p0_rdata, p1_rdata;
  logic          p0_ready, p1_ready;
  logic [AW-1:0] sram_addr;
  wire  [31:0]   sram_dq;
  logic          sram_we_n;
  state_t        dbg_state;

  sram_arbiter #(.WAIT_CYCLES(5), .BASE_ADDR(1024), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .p0_rd     (p0_rd),
    .p0_wr     (p0_wr),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p0_rdata  (p0_rdata),
    .p0_ready  (p0_ready),
    .p1_rd     (p1_rd),
    .p1_wr     (p1_wr),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p1_rdata  (p1_rdata),
    .p1_ready  (p1_ready),
    .sram_addr (sram_addr),
    .sram_dq   (sram_dq),
    .sram_we_n (sram_we_n),
    .dbg_state (dbg_state)
  );

  // ---------------- SRAM model ----------------
  // Unwritten words read as 0xA5000000 | word.
  logic [31:0] mem [int];
  logic [31:0] mem_rd = 32'hA5000000;
  assign sram_dq = sram_we_n ? mem_rd : {32{1'bz}};

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  logic [WW-1:0] exp_wr_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push_rsp(logic port, logic is_read, logic [AW-1:0] word, logic [31:0] data);
    exp_q.push_back({port, is_read, word, data});
  endfunction

  // Monitor: SRAM writes, ready pulses, model memory update.
  logic prev_we_low = 1'b0;
  logic prev_ready  = 1'b0;
  always @(negedge clk) begin
    logic [RW-1:0] e;
    logic [WW-1:0] w;
    if (!sram_we_n) begin
      chk("we_n_single_cycle", {63'd0, prev_we_low}, 64'd0);
      if (exp_wr_q.size() == 0) begin
        chk("unexpected_write", 64'd1, 64'd0);
      end else begin
        w = exp_wr_q.pop_front();
        chk("wr_addr", 64'(sram_addr), 64'(w[WW-1:32]));
        chk("wr_data", 64'(sram_dq), 64'(w[31:0]));
      end
      mem[int'(sram_addr)] = sram_dq;
    end
    prev_we_low = !sram_we_n;

    if (p0_ready || p1_ready) begin
      chk("ready_one_port", {63'd0, p0_ready & p1_ready}, 64'd0);
      chk("ready_single_cycle", {63'd0, prev_ready}, 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_ready", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("ready_port", {63'd0, p1_ready}, {63'd0, e[RW-1]});
        chk("ready_addr", 64'(sram_addr), 64'(e[AW+31:32]));
        if (e[RW-2]) chk("rdata", 64'(p1_ready ? p1_rdata : p0_rdata), 64'(e[31:0]));
      end
    end
    prev_ready = p0_ready | p1_ready;

    mem_rd = mem.exists(int'(sram_addr)) ? mem[int'(sram_addr)]
                                         : (32'hA5000000 | 32'(sram_addr));
  end

  // ---------------- driver tasks ----------------
  task automatic set_port(input logic port, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      p1_rd = rd; p1_wr = wr; p1_addr = addr; p1_wdata = wdata;
    end else begin
      p0_rd = rd; p0_wr = wr; p0_addr = addr; p0_wdata = wdata;
    end
  endtask

  // Issue one access and wait (bounded) for its ready; returns latency and
  // the cycle at which ready was seen.
  task automatic access(input logic port, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output int t_seen);
    int t0;
    @(negedge clk);
    set_port(port, rd, wr, addr, wdata);
    t0 = cyc;
    t_seen = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (port ? p1_ready : p0_ready) begin
        t_seen = cyc;
        break;
      end
    end
    set_port(port, 1'b0, 1'b0, 32'd0, 32'd0);
    if (t_seen < 0) chk("ready_timeout", 64'd1, 64'd0);
    lat = t_seen - t0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat, lat1, t0, t1, n_rdy;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_we_n", {63'd0, sram_we_n}, 64'd1);
    chk("rst_addr", 64'(sram_addr), 64'd0);
    chk("rst_ready", {62'd0, p1_ready, p0_ready}, 64'd0);
    chk("rst_p0_rdata", 64'(p0_rdata), 64'd0);
    chk("rst_p1_rdata", 64'(p1_rdata), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    rst = 1'b1;

    // Port 1 write to word 0
    exp_wr_q.push_back({17'd0, 32'hDEADBEEF});
    push_rsp(1'b1, 1'b0, 17'd0, 32'd0);
    access(1'b1, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, lat, t0);
    chk("wr_latency", 64'(lat), 64'd6);

    // Port 1 read back, value holds after the pulse
    push_rsp(1'b1, 1'b1, 17'd0, 32'hDEADBEEF);
    access(1'b1, 1'b1, 1'b0, 32'd1024, 32'd0, lat, t0);
    chk("rd_latency", 64'(lat), 64'd6);
    repeat (3) @(negedge clk);
    chk("p1_rdata_hold", 64'(p1_rdata), 64'hDEADBEEF);

    // Fresh reset, simultaneous requests: port 0 first
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    push_rsp(1'b0, 1'b1, 17'd1, 32'hA5000001);
    push_rsp(1'b1, 1'b0, 17'd2, 32'd0);
    exp_wr_q.push_back({17'd2, 32'h12345678});
    fork
      access(1'b0, 1'b1, 1'b0, 32'd1028, 32'd0, lat, t0);
      access(1'b1, 1'b0, 1'b1, 32'd1032, 32'h12345678, lat1, t1);
    join
    chk("tie_p0_latency", 64'(lat), 64'd6);
    chk("tie_gap", 64'(t1 - t0), 64'd7);

    // Both ports held for six transactions: strict alternation
    for (int k = 0; k < 3; k++) begin
      push_rsp(1'b0, 1'b1, 17'd3, 32'hA5000003);
      push_rsp(1'b1, 1'b0, 17'd5, 32'd0);
      exp_wr_q.push_back({17'd5, 32'hCAFE0005});
    end
    @(negedge clk);
    set_port(1'b0, 1'b1, 1'b0, 32'd1036, 32'd0);
    set_port(1'b1, 1'b0, 1'b1, 32'd1044, 32'hCAFE0005);
    n_rdy = 0;
    for (int i = 0; i < 200 && n_rdy < 6; i++) begin
      @(negedge clk);
      if (p0_ready || p1_ready) n_rdy++;
    end
    set_port(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_port(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("rr_ready_count", 64'(n_rdy), 64'd6);

    // Reset in the middle of a write at cnt=2: no ready pulse
    exp_wr_q.push_back({17'd6, 32'h55AA55AA});
    @(negedge clk);
    set_port(1'b0, 1'b0, 1'b1, 32'd1048, 32'h55AA55AA);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    set_port(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    chk("abort_we_n", {63'd0, sram_we_n}, 64'd1);
    chk("abort_state", 64'(dbg_state), 64'(IDLE));
    chk("abort_ready", {62'd0, p1_ready, p0_ready}, 64'd0);
    @(negedge clk); rst = 1'b1;
    repeat (10) @(negedge clk);
    push_rsp(1'b0, 1'b1, 17'd6, 32'h55AA55AA);
    access(1'b0, 1'b1, 1'b0, 32'd1048, 32'd0, lat, t0);
    chk("post_abort_latency", 64'(lat), 64'd6);

    // Address wrap, and rd+wr together acting as a write
    exp_wr_q.push_back({17'd0, 32'h0BADF00D});
    push_rsp(1'b0, 1'b0, 17'd0, 32'd0);
    access(1'b0, 1'b0, 1'b1, 32'd1024 + 32'd4 * 32'd131072, 32'h0BADF00D, lat, t0);
    exp_wr_q.push_back({17'd4, 32'h77777777});
    push_rsp(1'b0, 1'b0, 17'd4, 32'd0);
    access(1'b0, 1'b1, 1'b1, 32'd1040, 32'h77777777, lat, t0);
    chk("p0_rdata_kept_after_write", 64'(p0_rdata), 64'h55AA55AA);
    push_rsp(1'b1, 1'b1, 17'd4, 32'h77777777);
    access(1'b1, 1'b1, 1'b0, 32'd1040, 32'd0, lat, t0);
    push_rsp(1'b1, 1'b1, 17'd0, 32'h0BADF00D);
    access(1'b1, 1'b1, 1'b0, 32'd1024, 32'd0, lat, t0);

    // Final report
    repeat (4) @(negedge clk);
    chk("rsp_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("wr_queue_drained", 64'(exp_wr_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares one 17-bit-address, 32-bit-data asynchronous SRAM between two requesters.
- Port 0 is instruction fetch. Port 1 is the MEM-stage data access.
- Sequences each access with a fixed wait-state count and returns a one-cycle ready pulse to the granted requester.
- Sits between the pipeline stages and the SRAM pins. Contention is resolved round-robin.

Parameters:
- WAIT_CYCLES, 5: SRAM access cycles per transaction; must be 2 or more (covers the 30 ns read path plus turnaround).
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.
- ADDR_W, 17: SRAM word-address width.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- p0_rd  in  1  port 0 read request; held until p0_ready.
- p0_wr  in  1  port 0 write request; held until p0_ready.
- p0_addr  in  32  port 0 byte address.
- p0_wdata  in  32  port 0 write data.
- p0_rdata  out  32  port 0 read data; valid while p0_ready=1 and held afterwards.
- p0_ready  out  1  one-cycle completion pulse for port 0.
- p1_rd, p1_wr, p1_addr, p1_wdata, p1_rdata, p1_ready: same as port 0, for port 1.
- sram_addr  out  ADDR_W  SRAM word address.
- sram_dq  inout  32  SRAM data bus; driven only while sram_we_n=0, else high-Z.
- sram_we_n  out  1  SRAM write enable, active low.

Behaviour:
- Reset (rst=0, asynchronous, also mid-access):
  - state=IDLE; sram_we_n=1 immediately; sram_addr=0; sram_dq released.
  - p0_ready=p1_ready=0; p0_rdata=p1_rdata=0; last_grant=1, so port 0 wins the first tie.
  - Any in-flight access is aborted with no ready pulse.
- Request of a port = rd|wr. If both rd and wr are high on one port, the access is a write.
- Address mapping: word = (addr - BASE_ADDR) >> 2, truncated to ADDR_W bits (wraps modulo 2^ADDR_W). addr[1:0] is ignored.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE; sram_we_n=1.
  - One port requesting: grant it.
  - Both requesting: grant the port != last_grant.
  - On grant: latch port, op, word address and wdata; set last_grant; cnt=0; go to ACCESS.
- ACCESS:
  - sram_addr = latched word address.
  - Write: sram_we_n=0 and sram_dq=latched wdata only while cnt=0. sram_we_n=1 and bus released for cnt>=1 (bus turnaround).
  - Read: sram_we_n=1 throughout.
  - cnt increments each cycle. When cnt=WAIT_CYCLES-1:
    - for a read, capture sram_dq into the granted port's rdata register;
    - go to DONE.
- DONE:
  - The granted port's ready=1 for exactly this cycle; the other port's ready=0.
  - Write leaves rdata unchanged.
  - Next state is IDLE unconditionally; no request is sampled in DONE.
- Latency: a request sampled in IDLE at edge N gives ready high during cycle N+WAIT_CYCLES+1.
- Throughput: one access per WAIT_CYCLES+2 cycles.
- Requesters must deassert or change their request in the cycle ready is seen. A request still held in the following IDLE cycle is treated as a new access.
- Request dropped mid-access: the access still completes and ready still pulses.
- Latched address and data are immune to port changes after grant.
- Outputs sram_addr, sram_we_n, ready and rdata are registered. The sram_dq drive is controlled by the registered sram_we_n.

Decomposition:
- Shared package holds:
  - FSM state typedef {IDLE, ACCESS, DONE};
  - port index constants PORT_IF=0, PORT_MEM=1;
  - default WAIT_CYCLES and BASE_ADDR constants.
- One natural sub-module: sram_rr_grant. It is the combinational two-way round-robin picker: inputs req[1:0] and last_grant; outputs grant_valid and grant_idx.
- The FSM, counter and datapath stay in sram_arbiter.

Test Plan:
- Reset, then p1_wr=1, p1_addr=1024, p1_wdata=0xDEADBEEF with WAIT_CYCLES=5 -> sram_addr=0 and sram_we_n=0 for exactly one cycle with sram_dq=0xDEADBEEF; p1_ready pulses once, 6 cycles after grant; p0_ready stays 0.
- Then p1_rd=1, p1_addr=1024 -> sram_we_n stays 1; p1_rdata=0xDEADBEEF when p1_ready=1; the value holds after the pulse.
- Immediately after reset, p0_rd at addr 1028 and p1_wr at addr 1032 (data 0x12345678) asserted together -> port 0 served first (sram_addr=1); p1 served next (sram_addr=2); p1_ready arrives 7 cycles after p0_ready.
- Both ports hold requests continuously for 6 transactions -> grants alternate 0,1,0,1,0,1; no port is starved; each ready is a single-cycle pulse.
- Write in flight, rst driven low at cnt=2 -> sram_we_n=1 and bus high-Z immediately; no ready pulse; after release the FSM is in IDLE and a fresh read completes normally.
- p0_wr with p0_addr=1024+4*131072 -> wraps to sram_addr=0; p0_rd=p0_wr=1 together at addr 1040 -> performs a write to word 4.
